conin_uart_tx: RTL and testbench

- Console-input serializer for the TEP system simulation/FPGA top.
- Accepts bytes (e.g. preloaded console-input text) into a small FIFO.
- Emits each byte as an 8N1 asynchronous serial frame on a line driving sys RXD, giving the CPU's serial receiver real input.
- It is the upstream counterpart of the serial_in receiver that decodes sys TXD.

---
 rtl/conin_uart_tx_pkg.sv | 17 +
 rtl/conin_fifo.sv | 62 ++++++
 rtl/conin_uart_tx.sv | 131 +++++++++++++
 tb/tb_conin_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conin_uart_tx_pkg.sv
// Shared definitions for the console-input serializer: FSM encoding,
// frame geometry and serial line levels.
package conin_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/conin_fifo.sv
// Single-clock byte FIFO with registered full/empty/count and a sticky
// overflow flag for pushes attempted while full.
module conin_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          m_clock,
  input  logic                          p_reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    wr_data,
  output logic [7:0]                    rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;
  logic [CW-1:0] count_nxt;

  // full is the registered value, so a push while full is dropped even if
  // a pop frees a slot in the same cycle
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) count_nxt = count + CW'(1);
    else if (pop_ok && !push_ok) count_nxt = count - CW'(1);
  end

  always_ff @(posedge m_clock) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push && full) overflow <= 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/conin_uart_tx.sv
// Console-input serializer: queues bytes and emits them as 8N1 (or 8N2)
// frames on the line feeding the CPU's serial receiver.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | line high, waiting for a byte and tx_en
//   ST_START | start bit (low) for BAUD_DIV cycles
//   ST_DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
//   ST_STOP  | stop bit(s) high; may chain straight into START
module conin_uart_tx
  import conin_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV   = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                        m_clock,
  input  logic                        p_reset,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic                        tx_en,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy,
  output logic                        overflow,
  output logic                        rxd
);

  tx_state_e   state;
  logic [7:0]  shift;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        bit_end;
  logic        last_stop;
  logic        fifo_pop;
  logic [7:0]  fifo_data;

  assign bit_end   = (baud_cnt == 16'(BAUD_DIV - 1));
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  // Pop either from idle or at the very end of a stop bit, so consecutive
  // frames abut with no idle gap
  assign fifo_pop  = !empty && tx_en &&
                     (state == ST_IDLE || (state == ST_STOP && bit_end && last_stop));

  conin_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .push     (wr_en),
    .pop      (fifo_pop),
    .wr_data  (wr_data),
    .rd_data  (fifo_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state    <= ST_IDLE;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      rxd      <= LINE_IDLE;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (fifo_pop) begin
            shift <= fifo_data;
            state <= ST_START;
            rxd   <= LINE_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            rxd      <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              stop_idx <= 1'b0;
              state    <= ST_STOP;
              rxd      <= LINE_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              rxd     <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (last_stop) begin
              if (fifo_pop) begin
                shift <= fifo_data;
                state <= ST_START;
                rxd   <= LINE_START;
              end else begin
                state <= ST_IDLE;
                rxd   <= LINE_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conin_uart_tx.sv
// Bench for conin_uart_tx: directed stimulus with an expected-byte queue
// checked by a serial-line receiver monitor.
module tb_conin_uart_tx;

  localparam int BAUD  = 4;
  localparam int DEPTH = 16;
  localparam int STOPB = 1;

  logic       m_clock = 1'b0;
  logic       p_reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       overflow;
  logic       rxd;

  int         tests = 0;
  int         fails = 0;
  int         frames_seen = 0;
  logic [7:0] exp_q[$];
  bit         mon_aborted;

  always #5 m_clock = ~m_clock;

  conin_uart_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOPB)) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_en    (tx_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .busy     (busy),
    .overflow (overflow),
    .rxd      (rxd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge m_clock);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge m_clock);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge m_clock);
      if (p_reset) mon_aborted = 1'b1;
    end
  endtask

  // Receiver: samples each bit at its midpoint and scores against exp_q
  initial begin : monitor
    logic [7:0] d;
    logic       sb;
    logic       pb;
    forever begin
      @(negedge m_clock);
      if (rxd === 1'b0 && !p_reset) begin
        mon_aborted = 1'b0;
        mon_wait(BAUD / 2);
        sb = rxd;
        for (int i = 0; i < 8; i++) begin
          mon_wait(BAUD);
          d[i] = rxd;
        end
        mon_wait(BAUD);
        pb = rxd;
        if (!mon_aborted) begin
          frames_seen++;
          chk("start_bit", {31'd0, sb}, 32'd0);
          chk("stop_bit", {31'd0, pb}, 32'd1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL stray_frame: got byte %02h, expected no frame", d);
          end else begin
            chk("rx_data", {24'd0, d}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] lb;
    logic       e;
    int         n;
    int         cyc;
    int         f0;
    int         lows;

    p_reset = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    tx_en   = 1'b1;
    repeat (3) @(posedge m_clock);
    #1;
    chk("reset_rxd", {31'd0, rxd}, 32'd1);
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_count", {27'd0, count}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    p_reset = 1'b0;
    wr_en   = 1'b0;
    repeat (5) @(posedge m_clock);
    #1;
    chk("reset_no_byte_busy", {31'd0, busy}, 32'd0);
    chk("reset_no_byte_empty", {31'd0, empty}, 32'd1);

    // single byte, edge-exact waveform
    lb = 8'h41;
    exp_q.push_back(lb);
    push_byte(lb);
    chk("single_count_push", {27'd0, count}, 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge m_clock);
      #1;
      if (k <= 4) e = 1'b0;
      else if (k <= 36) e = lb[(k - 5) / 4];
      else e = 1'b1;
      chk($sformatf("single_rxd_edge%0d", k), {31'd0, rxd}, {31'd0, e});
      if (k == 1) begin
        chk("single_count_popped", {27'd0, count}, 32'd0);
        chk("single_busy_start", {31'd0, busy}, 32'd1);
      end
    end
    @(posedge m_clock);
    #1;
    chk("single_busy_end", {31'd0, busy}, 32'd0);

    // back-to-back frames
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    @(negedge m_clock);
    wr_en   = 1'b1;
    wr_data = 8'h55;
    @(negedge m_clock);
    wr_data = 8'hAA;
    @(posedge m_clock);
    #1;
    wr_en = 1'b0;
    n = busy ? 1 : 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge m_clock);
      #1;
      if (!busy) break;
      n++;
      if (n == 40) chk("b2b_first_stop", {31'd0, rxd}, 32'd1);
      if (n == 41) chk("b2b_second_start", {31'd0, rxd}, 32'd0);
    end
    chk("b2b_busy_cycles", n, 32'd80);
    chk("b2b_queue_drained", exp_q.size(), 32'd0);

    // overflow with transmitter held off
    tx_en = 1'b0;
    f0 = frames_seen;
    for (int i = 0; i < 17; i++) begin
      push_byte(8'h10 + 8'(i));
      if (i < 16) exp_q.push_back(8'h10 + 8'(i));
      if (i == 14) chk("ovf_not_full_15", {31'd0, full}, 32'd0);
      if (i == 15) begin
        chk("ovf_full_16", {31'd0, full}, 32'd1);
        chk("ovf_count_16", {27'd0, count}, 32'd16);
        chk("ovf_clear_16", {31'd0, overflow}, 32'd0);
      end
      if (i == 16) begin
        chk("ovf_set_17", {31'd0, overflow}, 32'd1);
        chk("ovf_count_17", {27'd0, count}, 32'd16);
        chk("ovf_full_17", {31'd0, full}, 32'd1);
      end
    end
    chk("txen_off_busy", {31'd0, busy}, 32'd0);
    chk("txen_off_rxd", {31'd0, rxd}, 32'd1);
    tx_en = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge m_clock);
      cyc++;
    end
    chk("ovf_drain_pending", exp_q.size(), 32'd0);
    repeat (60) @(posedge m_clock);
    #1;
    chk("ovf_frames", frames_seen - f0, 32'd16);
    chk("ovf_busy_end", {31'd0, busy}, 32'd0);
    chk("ovf_empty_end", {31'd0, empty}, 32'd1);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // reset during data bit 3 with two bytes queued
    f0 = frames_seen;
    push_byte(8'h33);
    push_byte(8'h77);
    push_byte(8'h99);
    repeat (16) @(posedge m_clock);
    #1;
    chk("mid_count_before", {27'd0, count}, 32'd2);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    p_reset = 1'b1;
    @(posedge m_clock);
    #1;
    chk("mid_reset_rxd", {31'd0, rxd}, 32'd1);
    chk("mid_reset_empty", {31'd0, empty}, 32'd1);
    chk("mid_reset_count", {27'd0, count}, 32'd0);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_overflow", {31'd0, overflow}, 32'd0);
    p_reset = 1'b0;
    lows = 0;
    repeat (100) begin
      @(posedge m_clock);
      #1;
      if (!rxd) lows++;
    end
    chk("mid_no_more_frames", lows, 32'd0);
    chk("mid_frames", frames_seen - f0, 32'd0);

    // "Hi" through the receiver monitor
    f0 = frames_seen;
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    push_byte(8'h48);
    push_byte(8'h69);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(posedge m_clock);
      cyc++;
    end
    repeat (10) @(posedge m_clock);
    #1;
    chk("hi_pending", exp_q.size(), 32'd0);
    chk("hi_frames", frames_seen - f0, 32'd2);
    chk("hi_idle_rxd", {31'd0, rxd}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
